// File: rtl/lpc_frame_reader.sv
// lpc_frame_reader
//
// Reads one frame of signed samples from port 2 of the 8192x16 sample RAM,
// starting at a latched base address, and streams them out in order as an
// Avalon-ST packet (sop on the first sample, eop on the last). The RAM has
// one cycle of read latency. A 2-entry prefetch FIFO absorbs it, so
// backpressure on out_ready never drops or repeats a sample. With out_ready
// held high the block sustains one sample per clock.
//
// Optional build macro: LPC_READER_PREEMPH_EN
//    When defined, each RAM word passes through y = x - x_prev + (x_prev >>> 5)
//    before it is written into the FIFO. The result is saturated to the
//    DATA_W range, and x_prev is cleared on every accepted start.
//    When undefined, out_data is the raw RAM word.
//
// Ports
//    clk, reset_n        system clock, asynchronous active-low reset
//    start, abort        frame request (IDLE only) / cancel frame in progress
//    base_addr           first RAM word address, latched on an accepted start
//    frame_len           samples per frame (0..2^ADDR_W), latched on start
//    busy, done          RUN/DRAIN indicator / 1-cycle end-of-frame pulse
//    mem_*               RAM port-2 master (read only; write side tied off)
//    out_data/valid/ready/sop/eop   Avalon-ST source to the LPC stage
//
// State | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; no reads issued
// RUN   | issuing reads until frame_len addresses have been requested
// DRAIN | all reads issued; waiting for the eop sample to be accepted
module lpc_frame_reader #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 14
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  frame_len,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   output logic [1:0]        mem_byteenable,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t            state;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  issued;
   logic              inflight;
   logic              infl_sop;
   logic              infl_eop;
   logic [DATA_W-1:0] fifo_data [2];
   logic [1:0]        fifo_sop;
   logic [1:0]        fifo_eop;
   logic              rd_ptr;
   logic              wr_ptr;
   logic [1:0]        count;
   logic              pop;
   logic              issue;
   logic [1:0]        committed;
   logic [DATA_W-1:0] wr_data;

   assign mem_clken      = 1'b1;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 2'b11;
   assign mem_writedata  = '0;

   assign busy      = (state != IDLE);
   assign out_valid = (count != 2'd0);
   assign out_data  = fifo_data[rd_ptr];
   assign out_sop   = out_valid & fifo_sop[rd_ptr];
   assign out_eop   = out_valid & fifo_eop[rd_ptr];
   assign pop       = out_valid & out_ready;

   // FIFO slots already spoken for after this cycle's pop. Counting the pop
   // here lets a new read issue in the same cycle a slot frees up. That is
   // what keeps the stream gap-free with only two entries.
   assign committed = count - {1'b0, pop} + {1'b0, inflight};
   assign issue     = (state == RUN) & ~abort & (committed < 2'd2);
   assign mem_chipselect = issue;

`ifdef LPC_READER_PREEMPH_EN
   localparam int PW = DATA_W + 2;

   logic [DATA_W-1:0] x_prev;
   logic signed [PW-1:0] x_ext;
   logic signed [PW-1:0] p_ext;
   logic signed [PW-1:0] pe_sum;

   always_comb begin
      x_ext  = {{2{mem_readdata[DATA_W-1]}}, mem_readdata};
      p_ext  = {{2{x_prev[DATA_W-1]}}, x_prev};
      pe_sum = x_ext - p_ext + (p_ext >>> 5);
      // In range when the bits above the DATA_W sign bit all match it.
      if (pe_sum[PW-1:DATA_W-1] == {3{pe_sum[PW-1]}})
         wr_data = pe_sum[DATA_W-1:0];
      else if (pe_sum[PW-1])
         wr_data = {1'b1, {(DATA_W-1){1'b0}}};
      else
         wr_data = {1'b0, {(DATA_W-1){1'b1}}};
   end
`else
   assign wr_data = mem_readdata;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         done         <= 1'b0;
         mem_address  <= '0;
         len_q        <= '0;
         issued       <= '0;
         inflight     <= 1'b0;
         infl_sop     <= 1'b0;
         infl_eop     <= 1'b0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_sop     <= '0;
         fifo_eop     <= '0;
         rd_ptr       <= 1'b0;
         wr_ptr       <= 1'b0;
         count        <= '0;
`ifdef LPC_READER_PREEMPH_EN
         x_prev       <= '0;
`endif
      end else begin
         done <= 1'b0;
         if (abort) begin
            // Drop everything, including a read whose data arrives this cycle.
            state    <= IDLE;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= '0;
         end else begin
            inflight <= issue;
            infl_sop <= (issued == '0);
            infl_eop <= (issued == len_q - LEN_W'(1));

            if (inflight) begin
               fifo_data[wr_ptr] <= wr_data;
               fifo_sop[wr_ptr]  <= infl_sop;
               fifo_eop[wr_ptr]  <= infl_eop;
               wr_ptr            <= ~wr_ptr;
`ifdef LPC_READER_PREEMPH_EN
               x_prev            <= mem_readdata;
`endif
            end
            if (pop)
               rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};

            if (issue) begin
               mem_address <= mem_address + ADDR_W'(1);
               issued      <= issued + LEN_W'(1);
            end

            case (state)
               IDLE: begin
                  if (start) begin
`ifdef LPC_READER_PREEMPH_EN
                     x_prev <= '0;
`endif
                     if (frame_len != '0) begin
                        state       <= RUN;
                        len_q       <= frame_len;
                        mem_address <= base_addr;
                        issued      <= '0;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               RUN: begin
                  if (issue && ((issued + LEN_W'(1)) == len_q))
                     state <= DRAIN;
               end
               DRAIN: begin
                  if (pop && out_eop) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lpc_frame_reader.sv
module tb_lpc_frame_reader;

   localparam int AW = 13;
   localparam int DW = 16;
   localparam int LW = 14;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] frame_len = '0;
   logic          busy, done;
   logic [AW-1:0] mem_address;
   logic          mem_chipselect, mem_clken, mem_write;
   logic [1:0]    mem_byteenable;
   logic [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_readdata = '0;
   logic [DW-1:0] out_data;
   logic          out_valid, out_sop, out_eop;
   logic          out_ready = 1'b0;

   lpc_frame_reader dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .base_addr(base_addr), .frame_len(frame_len), .busy(busy), .done(done),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect),
      .mem_clken(mem_clken), .mem_write(mem_write),
      .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop)
   );

   always #5 clk = ~clk;

   // Sample RAM: one-cycle read latency
   logic [DW-1:0] ram [0:8191];
   always @(posedge clk) if (mem_chipselect) mem_readdata <= ram[mem_address];

   int total = 0;
   int bad = 0;

   // Monitor, sampling on the falling edge
   int            cyc = 0;
   int            cs_cnt, done_cnt, done_cyc, valid_cnt, first_valid;
   int            stab_err, out_err;
   int            addr_q [$];
   logic [DW-1:0] hs_d [$];
   logic          hs_sop [$];
   logic          hs_eop [$];
   int            hs_cyc [$];
   logic          prev_stall;
   logic [DW-1:0] pd;
   logic          ps, pe;
   logic [DW-1:0] exp_q [$];

   always @(negedge clk) begin
      cyc++;
      if (reset_n) begin
         if (mem_chipselect) begin
            cs_cnt++;
            addr_q.push_back(int'(mem_address));
         end
         if (out_valid && out_ready) begin
            hs_d.push_back(out_data);
            hs_sop.push_back(out_sop);
            hs_eop.push_back(out_eop);
            hs_cyc.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (out_valid) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
         end
         if (prev_stall && !(out_valid === 1'b1 && out_data === pd &&
                             out_sop === ps && out_eop === pe))
            stab_err++;
         prev_stall = out_valid && !out_ready && !abort;
         pd = out_data; ps = out_sop; pe = out_eop;
         if (cs_cnt - hs_d.size() > 2) out_err++;
      end
   end

   task automatic clear_mon();
      cs_cnt = 0; done_cnt = 0; done_cyc = -1; valid_cnt = 0; first_valid = -1;
      stab_err = 0; out_err = 0; prev_stall = 1'b0;
      addr_q.delete(); hs_d.delete(); hs_sop.delete(); hs_eop.delete(); hs_cyc.delete();
   endtask

   // Reference model: expected packet contents from RAM contents and the frame rules
   function automatic int preemph(input int x, input int p);
      int y;
      y = x - p + (p >>> 5);
      if (y > 32767) y = 32767;
      if (y < -32768) y = -32768;
      return y;
   endfunction

   function automatic void build_exp(input int base, input int len);
      int p, x;
      exp_q.delete();
      p = 0;
      for (int i = 0; i < len; i++) begin
         x = int'($signed(ram[(base + i) % 8192]));
`ifdef LPC_READER_PREEMPH_EN
         exp_q.push_back(DW'(preemph(x, p)));
`else
         exp_q.push_back(DW'(x));
`endif
         p = x;
      end
   endfunction

   function automatic logic rdy(input int mode, input int k);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((k % 3) == 0);
      return 1'($urandom_range(0, 1));
   endfunction

   // Stimulus: one start pulse, then drive out_ready until done (bounded).
   // inj_at > 0 fires a second start (base 3000, len 3) while busy.
   task automatic run_frame(input int base, input int len, input int mode,
                            input int inj_at, output int s_cyc, output bit tmo);
      int budget;
      clear_mon();
      budget = len * 4 + 100;
      @(posedge clk); #1;
      base_addr = AW'(base); frame_len = LW'(len); start = 1'b1;
      out_ready = rdy(mode, 0);
      s_cyc = cyc;
      tmo = 1'b1;
      for (int k = 1; k < budget; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         base_addr = AW'($urandom_range(0, 8191));
         frame_len = LW'($urandom_range(1, 8192));
         if (k == inj_at) begin
            start = 1'b1; base_addr = AW'(3000); frame_len = LW'(3);
         end
         out_ready = rdy(mode, k);
         if (done_cnt != 0) begin
            tmo = 1'b0;
            break;
         end
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      total++; if ({out_sop, out_eop} !== 2'b00) begin bad++; $display("FAIL reset_marks: got %b want 00", {out_sop, out_eop}); end
      total++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL reset_cs: got %b want 0", mem_chipselect); end
      total++; if (mem_address !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", mem_address); end
      total++; if ({mem_clken, mem_write, mem_byteenable} !== 4'b1011 || mem_writedata !== '0) begin
         bad++; $display("FAIL tieoffs: got %b/%0h want 1011/0", {mem_clken, mem_write, mem_byteenable}, mem_writedata);
      end
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int s; bit tmo;
      run_frame(0, 4, 0, 0, s, tmo);
      build_exp(0, 4);
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL basic_timeout: got %b want 0", tmo); end
      total++; if (hs_d.size() != 4) begin bad++; $display("FAIL basic_count: got %0d want 4", hs_d.size()); end
      for (int i = 0; i < 4 && i < hs_d.size(); i++) begin
         total++; if (hs_d[i] !== exp_q[i]) begin bad++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, hs_d[i], exp_q[i]); end
         total++; if (hs_sop[i] !== (i == 0) || hs_eop[i] !== (i == 3)) begin
            bad++; $display("FAIL basic_marks[%0d]: got sop=%b eop=%b", i, hs_sop[i], hs_eop[i]);
         end
      end
      total++; if (first_valid != s + 4) begin bad++; $display("FAIL basic_latency: got %0d want %0d", first_valid - s, 4); end
      if (hs_cyc.size() == 4) begin
         total++; if (hs_cyc[3] - hs_cyc[0] != 3) begin bad++; $display("FAIL basic_gapless: got span %0d want 3", hs_cyc[3] - hs_cyc[0]); end
         total++; if (done_cyc != hs_cyc[3] + 1) begin bad++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, hs_cyc[3] + 1); end
      end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
      total++; if (cs_cnt != 4) begin bad++; $display("FAIL basic_cs_cnt: got %0d want 4", cs_cnt); end
   endtask

   task automatic test_wrap();
      int s; bit tmo;
      int exp_a [4] = '{8190, 8191, 0, 1};
      run_frame(8190, 4, 0, 0, s, tmo);
      build_exp(8190, 4);
      total++; if (addr_q.size() != 4) begin bad++; $display("FAIL wrap_cs_cnt: got %0d want 4", addr_q.size()); end
      for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
         total++; if (addr_q[i] != exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, addr_q[i], exp_a[i]); end
      end
      total++; if (hs_d.size() != 4) begin bad++; $display("FAIL wrap_count: got %0d want 4", hs_d.size()); end
      for (int i = 0; i < 4 && i < hs_d.size(); i++) begin
         total++; if (hs_d[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, hs_d[i], exp_q[i]); end
      end
   endtask

   task automatic test_stall();
      int s; bit tmo; int b;
      b = $urandom_range(0, 8191);
      run_frame(b, 8, 1, 0, s, tmo);
      build_exp(b, 8);
      total++; if (tmo !== 1'b0) begin bad++; $display("FAIL stall_timeout: got %b want 0", tmo); end
      total++; if (hs_d.size() != 8) begin bad++; $display("FAIL stall_count: got %0d want 8", hs_d.size()); end
      for (int i = 0; i < 8 && i < hs_d.size(); i++) begin
         total++; if (hs_d[i] !== exp_q[i] || hs_sop[i] !== (i == 0) || hs_eop[i] !== (i == 7)) begin
            bad++; $display("FAIL stall_beat[%0d]: got %0d/%b/%b want %0d", i, hs_d[i], hs_sop[i], hs_eop[i], exp_q[i]);
         end
      end
      total++; if (stab_err != 0) begin bad++; $display("FAIL stall_stable: got %0d unstable cycles want 0", stab_err); end
      total++; if (out_err != 0) begin bad++; $display("FAIL stall_outstanding: got %0d violations want 0", out_err); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL stall_done: got %0d want 1", done_cnt); end
   endtask

   task automatic test_zero_len();
      int s; bit tmo;
      run_frame(5, 0, 0, 0, s, tmo);
      repeat (4) @(negedge clk);
      total++; if (done_cyc != s + 2) begin bad++; $display("FAIL zero_done_time: got %0d want %0d", done_cyc - s, 2); end
      total++; if (done_cnt != 1) begin bad++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
      total++; if (valid_cnt != 0) begin bad++; $display("FAIL zero_valid: got %0d want 0", valid_cnt); end
      total++; if (cs_cnt != 0) begin bad++; $display("FAIL zero_reads: got %0d want 0", cs_cnt); end
   endtask

   task automatic test_start_busy();
      int s; bit tmo;
      run_frame(100, 6, 0, 2, s, tmo);
      build_exp(100, 6);
      total++; if (hs_d.size() != 6) begin bad++; $display("FAIL busy_count: got %0d want 6", hs_d.size()); end
      for (int i = 0; i < 6 && i < hs_d.size(); i++) begin
         total++; if (hs_d[i] !== exp_q[i]) begin bad++; $display("FAIL busy_data[%0d]: got %0d want %0d", i, hs_d[i], exp_q[i]); end
      end
      total++; if (cs_cnt != 6 || done_cnt != 1) begin bad++; $display("FAIL busy_reads_done: got %0d/%0d want 6/1", cs_cnt, done_cnt); end
   endtask

   task automatic test_abort();
      int s, n, b; bit tmo;
      b = $urandom_range(0, 8191);
      clear_mon();
      @(posedge clk); #1;
      base_addr = AW'(b); frame_len = LW'(16); start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (hs_d.size() < 3 && n < 50) begin @(posedge clk); #1; n++; end
      total++; if (n >= 50) begin bad++; $display("FAIL abort_wait: got %0d beats want 3", hs_d.size()); end
      abort = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      total++; if (done_cnt != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", done_cnt); end
      build_exp(b, 16);
      total++; if (hs_d.size() != 3) begin bad++; $display("FAIL abort_beats: got %0d want 3", hs_d.size()); end
      for (int i = 0; i < 3 && i < hs_d.size(); i++) begin
         total++; if (hs_d[i] !== exp_q[i]) begin bad++; $display("FAIL abort_data[%0d]: got %0d want %0d", i, hs_d[i], exp_q[i]); end
      end
      b = $urandom_range(0, 8191);
      run_frame(b, 5, 2, 0, s, tmo);
      build_exp(b, 5);
      total++; if (tmo !== 1'b0 || hs_d.size() != 5) begin bad++; $display("FAIL abort_next_count: got %0d want 5", hs_d.size()); end
      for (int i = 0; i < 5 && i < hs_d.size(); i++) begin
         total++; if (hs_d[i] !== exp_q[i] || hs_sop[i] !== (i == 0) || hs_eop[i] !== (i == 4)) begin
            bad++; $display("FAIL abort_next_beat[%0d]: got %0d/%b/%b want %0d", i, hs_d[i], hs_sop[i], hs_eop[i], exp_q[i]);
         end
      end
      total++; if (first_valid != s + 4) begin bad++; $display("FAIL abort_next_latency: got %0d want 4", first_valid - s); end
   endtask

   task automatic test_abort_idle();
      clear_mon();
      @(posedge clk); #1;
      base_addr = AW'(7); frame_len = LW'(5); start = 1'b1; abort = 1'b1;
      @(posedge clk); #1 start = 1'b0; abort = 1'b0;
      repeat (6) @(negedge clk);
      total++; if (cs_cnt != 0 || busy !== 1'b0 || done_cnt != 0) begin
         bad++; $display("FAIL abort_idle: got reads=%0d busy=%b done=%0d want 0/0/0", cs_cnt, busy, done_cnt);
      end
   endtask

   task automatic test_random();
      int s, b, len, mode, errs; bit tmo;
      for (int f = 0; f < 12; f++) begin
         b = $urandom_range(0, 8191);
         len = (f == 0) ? 1 : $urandom_range(1, 40);
         mode = $urandom_range(0, 2);
         run_frame(b, len, mode, 0, s, tmo);
         build_exp(b, len);
         total++; if (tmo !== 1'b0 || hs_d.size() != len) begin
            bad++; $display("FAIL rand%0d_count: got %0d want %0d", f, hs_d.size(), len);
         end
         errs = 0;
         for (int i = 0; i < len && i < hs_d.size(); i++)
            if (hs_d[i] !== exp_q[i] || hs_sop[i] !== (i == 0) || hs_eop[i] !== (i == len - 1)) errs++;
         total++; if (errs != 0) begin bad++; $display("FAIL rand%0d_beats: got %0d bad beats want 0", f, errs); end
         total++; if (cs_cnt != len || done_cnt != 1) begin
            bad++; $display("FAIL rand%0d_reads_done: got %0d/%0d want %0d/1", f, cs_cnt, done_cnt, len);
         end
         total++; if (stab_err != 0 || out_err != 0) begin
            bad++; $display("FAIL rand%0d_flow: got stab=%0d outstanding=%0d want 0/0", f, stab_err, out_err);
         end
      end
   endtask

   task automatic test_full_len();
      int s, b, errs; bit tmo;
      b = $urandom_range(0, 8191);
      run_frame(b, 8192, 0, 0, s, tmo);
      build_exp(b, 8192);
      total++; if (tmo !== 1'b0 || hs_d.size() != 8192 || cs_cnt != 8192) begin
         bad++; $display("FAIL full_count: got %0d beats %0d reads want 8192", hs_d.size(), cs_cnt);
      end
      errs = 0;
      for (int i = 0; i < 8192 && i < hs_d.size(); i++)
         if (hs_d[i] !== exp_q[i] || hs_sop[i] !== (i == 0) || hs_eop[i] !== (i == 8191)) errs++;
      total++; if (errs != 0) begin bad++; $display("FAIL full_beats: got %0d bad beats want 0", errs); end
      if (hs_cyc.size() == 8192) begin
         total++; if (hs_cyc[8191] - hs_cyc[0] != 8191) begin bad++; $display("FAIL full_gapless: got span %0d want 8191", hs_cyc[8191] - hs_cyc[0]); end
      end
   endtask

`ifdef LPC_READER_PREEMPH_EN
   task automatic test_filter();
      int s; bit tmo;
      ram[200] = 16'd1000; ram[201] = 16'd1000;
      run_frame(200, 2, 0, 0, s, tmo);
      total++; if (hs_d.size() != 2) begin bad++; $display("FAIL filt_a_count: got %0d want 2", hs_d.size()); end
      else begin
         total++; if (hs_d[0] !== 16'd1000) begin bad++; $display("FAIL filt_a0: got %0d want 1000", hs_d[0]); end
         total++; if (hs_d[1] !== 16'd31) begin bad++; $display("FAIL filt_a1: got %0d want 31", hs_d[1]); end
      end
      ram[300] = 16'h8000; ram[301] = 16'h7fff;
      run_frame(300, 2, 0, 0, s, tmo);
      total++; if (hs_d.size() != 2) begin bad++; $display("FAIL filt_b_count: got %0d want 2", hs_d.size()); end
      else begin
         total++; if (hs_d[0] !== 16'h8000) begin bad++; $display("FAIL filt_b0: got %0h want 8000", hs_d[0]); end
         total++; if (hs_d[1] !== 16'h7fff) begin bad++; $display("FAIL filt_b1_sat: got %0h want 7fff", hs_d[1]); end
      end
   endtask
`endif

   task automatic test_reset_mid();
      int s; bit tmo;
      clear_mon();
      @(posedge clk); #1;
      base_addr = AW'(40); frame_len = LW'(20); start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      total++; if ({busy, out_valid, mem_chipselect, done} !== 4'b0000 || mem_address !== '0) begin
         bad++; $display("FAIL async_reset: got busy/valid/cs/done=%b addr=%0d want 0000/0", {busy, out_valid, mem_chipselect, done}, mem_address);
      end
      @(posedge clk); #1 reset_n = 1'b1;
      run_frame(40, 3, 0, 0, s, tmo);
      build_exp(40, 3);
      total++; if (hs_d.size() != 3 || hs_d[0] !== exp_q[0] || hs_sop[0] !== 1'b1) begin
         bad++; $display("FAIL post_reset_frame: got %0d beats want 3 with sop and first=%0d", hs_d.size(), exp_q[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) ram[i] = DW'(i);
      clear_mon();
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_zero_len();
      test_start_busy();
      test_abort();
      test_abort_idle();
      for (int i = 0; i < 8192; i++) ram[i] = DW'($urandom);
      test_random();
      test_full_len();
`ifdef LPC_READER_PREEMPH_EN
      test_filter();
`endif
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/lpc_frame_reader.md
Name: lpc_frame_reader

Overview:
- Downstream consumer of the 8192x16 dual-port sample RAM (port 2 / s2 side): fetches one frame of 16-bit samples, starting at a given word address, and emits them in order as an Avalon-ST packet to the LPC analysis stage (autocorrelation).
- Handles the RAM's 1-cycle read latency with a 2-entry prefetch FIFO, so out_ready backpressure never loses or duplicates a sample.
- Sustains one sample per clock.

Parameters:
- ADDR_W, 13, RAM word-address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16, sample width, signed two's complement.
- LEN_W, 14, frame_len width; must hold 2^ADDR_W.

Ports:
- clk  input  1  single system clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  1-cycle request; sampled only in IDLE.
- abort  input  1  cancels the frame in progress.
- base_addr  input  ADDR_W  first sample address; latched on an accepted start.
- frame_len  input  LEN_W  samples per frame, 0..8192; latched on an accepted start.
- busy  output  1  high in RUN and DRAIN.
- done  output  1  1-cycle pulse after the last sample handshake.
- mem_address  output  ADDR_W  RAM port-2 address.
- mem_chipselect  output  1  read strobe.
- mem_clken  output  1  tied 1.
- mem_write  output  1  tied 0.
- mem_byteenable  output  2  tied 2'b11.
- mem_writedata  output  DATA_W  tied 0.
- mem_readdata  input  DATA_W  valid in the cycle after the edge that captures mem_address while mem_chipselect=1.
- out_data  output  DATA_W  sample.
- out_valid  output  1  sample available.
- out_ready  input  1  sink accepts.
- out_sop  output  1  first sample of the frame; qualified by out_valid.
- out_eop  output  1  last sample of the frame; qualified by out_valid.

Behaviour:
- Reset, asynchronous on reset_n low:
  - state=IDLE.
  - busy, done, out_valid, out_sop, out_eop, mem_chipselect = 0.
  - mem_address = 0; FIFO empty.
  - All counters = 0.
- States:
  - IDLE -> RUN on start with frame_len != 0.
  - IDLE -> IDLE with done pulsed on the next cycle when start is asserted with frame_len == 0; no reads, no output.
  - RUN -> DRAIN when issued count == frame_len.
  - DRAIN -> IDLE on the handshake of the eop sample; done=1 for one cycle.
- Read issue rule: a read issues (mem_chipselect=1) only when in RUN and (FIFO occupancy + reads in flight) < 2.
  - After each issue, mem_address increments.
  - Address 8191 wraps to 0.
- Ordering and flow control:
  - Returned data is written to the FIFO the cycle after its issue.
  - out_* presents the FIFO head.
  - Handshake = out_valid & out_ready.
  - out_data, out_sop and out_eop stay stable while out_valid=1 and out_ready=0.
- Latency and throughput:
  - First out_valid rises after the 2nd rising edge following the edge that samples start.
  - With out_ready held at 1: frame_len consecutive valid cycles, no gaps.
- Markers:
  - out_sop on handshake index 0; out_eop on index frame_len-1.
  - frame_len=1 gives sop and eop on the same beat.
- start while busy: ignored; latched parameters are unchanged.
- abort:
  - Wins over everything except reset.
  - Next cycle: state=IDLE, FIFO flushed, out_valid=0, any in-flight return discarded, no done pulse.
  - abort together with start in IDLE: start is ignored.

Optional Feature:
- Macro: LPC_READER_PREEMPH_EN.
- Defined: samples pass through a pre-emphasis filter before entering the FIFO.
  - y = x - x_prev + (x_prev >>> 5), i.e. coefficient 31/32.
  - Computed at 18 bits signed, saturated to [-32768, 32767].
  - x_prev is cleared to 0 at every accepted start.
  - Latency is unchanged: the filter is combinational on the FIFO write path.
- Undefined: out_data equals the raw RAM word; no extra registers.

Test Plan:
- RAM[i]=i, base=0, len=4, out_ready=1 -> data 0,1,2,3 on 4 consecutive cycles; sop on 0, eop on 3; done 1 cycle after beat 3; 4 chipselect pulses total.
- base=8190, len=4 -> mem_address sequence 8190, 8191, 0, 1; data in that order.
- len=8, out_ready toggled 1,0,0,1,... -> exactly 8 handshakes, no duplicates; data stable during stalls; never more than 2 reads outstanding.
- len=0 start -> done pulse, out_valid never high; start during busy -> ignored, frame completes with original len.
- abort after 3 beats of len=16 -> IDLE next cycle, out_valid=0, no done; a new start gives a clean frame with sop on its first sample.
- Filter build: RAM = 1000, 1000 -> out 1000, 31; RAM = -32768, 32767 -> second output saturates to 32767.
